// File: rtl/vga_timing_controller_if.sv
// Bus between the VGA mode controller and whoever drives it: mode requests,
// custom-field writes, the frame_end level, and the timing/status outputs.
interface vga_timing_controller_if #(
  parameter int WIDTH = 10
);

  // Requests and configuration from the host / vsync path
  logic             mode_req;
  logic [1:0]       mode_sel;
  logic             frame_end;
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [WIDTH-1:0] cfg_data;

  // Horizontal timing fields to the hsync generator
  logic [WIDTH-1:0] h_sp;
  logic [WIDTH-1:0] h_bp;
  logic [WIDTH-1:0] h_av;
  logic [WIDTH-1:0] h_fp;

  // Vertical timing fields to the vsync generator
  logic [WIDTH-1:0] v_sp;
  logic [WIDTH-1:0] v_bp;
  logic [WIDTH-1:0] v_av;
  logic [WIDTH-1:0] v_fp;

  // Status
  logic             timing_reset;
  logic             video_enable;
  logic             busy;
  logic             mode_ack;
  logic [1:0]       current_mode;

  // Host side: issues requests, observes timing and status
  modport master (
    output mode_req, mode_sel, frame_end, cfg_we, cfg_addr, cfg_data,
    input  h_sp, h_bp, h_av, h_fp, v_sp, v_bp, v_av, v_fp,
    input  timing_reset, video_enable, busy, mode_ack, current_mode
  );

  // Controller side
  modport slave (
    input  mode_req, mode_sel, frame_end, cfg_we, cfg_addr, cfg_data,
    output h_sp, h_bp, h_av, h_fp, v_sp, v_bp, v_av, v_fp,
    output timing_reset, video_enable, busy, mode_ack, current_mode
  );

endinterface

// File: rtl/vga_timing_controller.sv
// VGA mode controller. Holds the eight timing fields feeding the hsync/vsync
// generators and only switches modes on a frame boundary. Each switch pulses a
// generator reset for one cycle and then blanks video for SETTLE_FRAMES frames.
module vga_timing_controller #(
  parameter int WIDTH         = 10,
  parameter int SETTLE_FRAMES = 2,
  parameter int DEFAULT_MODE  = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  vga_timing_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PEND,
    ST_SWAP,
    ST_SETTLE
  } state_t;

  typedef logic [7:0][WIDTH-1:0] fields_t;

  localparam int CW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_FRAME = CW'((SETTLE_FRAMES > 0) ? SETTLE_FRAMES - 1 : 0);
  localparam logic [1:0]    RESET_MODE = 2'(DEFAULT_MODE);

  // The small simulation mode; also the power-on contents of the custom registers.
  function automatic fields_t simSmallFields();
    fields_t t;
    t[0] = WIDTH'(2);
    t[1] = WIDTH'(3);
    t[2] = WIDTH'(5);
    t[3] = WIDTH'(2);
    t[4] = WIDTH'(2);
    t[5] = WIDTH'(3);
    t[6] = WIDTH'(5);
    t[7] = WIDTH'(2);
    return t;
  endfunction

  // Field order: H sp,bp,av,fp then V sp,bp,av,fp (same as cfg_addr).
  function automatic fields_t modeFields(input logic [1:0] mode, input fields_t custom);
    fields_t t;
    t = custom;
    case (mode)
      2'd0: begin
        t[0] = WIDTH'(96);
        t[1] = WIDTH'(48);
        t[2] = WIDTH'(640);
        t[3] = WIDTH'(16);
        t[4] = WIDTH'(2);
        t[5] = WIDTH'(33);
        t[6] = WIDTH'(480);
        t[7] = WIDTH'(10);
      end
      2'd1: begin
        t[0] = WIDTH'(128);
        t[1] = WIDTH'(88);
        t[2] = WIDTH'(800);
        t[3] = WIDTH'(40);
        t[4] = WIDTH'(4);
        t[5] = WIDTH'(23);
        t[6] = WIDTH'(600);
        t[7] = WIDTH'(1);
      end
      2'd2:    t = simSmallFields();
      default: t = custom;
    endcase
    return t;
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_frameCnt;
  logic [1:0]    r_reqMode;
  logic [1:0]    r_currentMode;
  fields_t       r_timing;
  fields_t       r_custom;
  logic          r_frameEndD;
  logic          r_timingReset;
  logic          r_videoEnable;
  logic          r_busy;
  logic          r_modeAck;

  logic          w_feEdge;

  assign w_feEdge = bus.frame_end & ~r_frameEndD;

  // Delay frame_end by one cycle so a held-high level yields a single edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_frameEndD <= 1'b0;
    end else begin
      r_frameEndD <= bus.frame_end;
    end
  end

  // Custom-mode field registers; a zero-length field is never allowed, so 0 is stored as 1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_custom <= simSmallFields();
    end else if (bus.cfg_we) begin
      r_custom[bus.cfg_addr] <= (bus.cfg_data == '0) ? WIDTH'(1) : bus.cfg_data;
    end
  end

  // Mode-switch sequencer: RUN -> PEND (wait frame edge) -> SWAP (reset pulse) -> SETTLE -> RUN.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_SETTLE;
      r_frameCnt    <= '0;
      r_reqMode     <= RESET_MODE;
      r_currentMode <= RESET_MODE;
      r_timing      <= modeFields(RESET_MODE, simSmallFields());
      r_timingReset <= 1'b1;
      r_videoEnable <= 1'b0;
      r_busy        <= 1'b1;
      r_modeAck     <= 1'b0;
    end else begin
      r_modeAck <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_timingReset <= 1'b0;
          r_videoEnable <= 1'b1;
          r_busy        <= 1'b0;
          if (bus.mode_req) begin
            if (bus.mode_sel != r_currentMode) begin
              r_reqMode <= bus.mode_sel;
              r_busy    <= 1'b1;
              r_state   <= ST_PEND;
            end else begin
              r_modeAck <= 1'b1;
            end
          end
        end

        ST_PEND: begin
          r_timingReset <= 1'b0;
          r_videoEnable <= 1'b1;
          r_busy        <= 1'b1;
          if (w_feEdge) begin
            r_timing      <= modeFields(r_reqMode, r_custom);
            r_currentMode <= r_reqMode;
            r_timingReset <= 1'b1;
            r_videoEnable <= 1'b0;
            r_state       <= ST_SWAP;
          end
        end

        ST_SWAP: begin
          r_timingReset <= 1'b0;
          r_frameCnt    <= '0;
          if (SETTLE_FRAMES == 0) begin
            r_videoEnable <= 1'b1;
            r_busy        <= 1'b0;
            r_modeAck     <= 1'b1;
            r_state       <= ST_RUN;
          end else begin
            r_videoEnable <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          r_timingReset <= 1'b0;
          r_videoEnable <= 1'b0;
          r_busy        <= 1'b1;
          if (SETTLE_FRAMES == 0 || (w_feEdge && r_frameCnt == LAST_FRAME)) begin
            r_videoEnable <= 1'b1;
            r_busy        <= 1'b0;
            r_modeAck     <= 1'b1;
            r_frameCnt    <= '0;
            r_state       <= ST_RUN;
          end else if (w_feEdge) begin
            r_frameCnt <= r_frameCnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_SETTLE;
        end
      endcase
    end
  end

  assign bus.h_sp         = r_timing[0];
  assign bus.h_bp         = r_timing[1];
  assign bus.h_av         = r_timing[2];
  assign bus.h_fp         = r_timing[3];
  assign bus.v_sp         = r_timing[4];
  assign bus.v_bp         = r_timing[5];
  assign bus.v_av         = r_timing[6];
  assign bus.v_fp         = r_timing[7];
  assign bus.timing_reset = r_timingReset;
  assign bus.video_enable = r_videoEnable;
  assign bus.busy         = r_busy;
  assign bus.mode_ack     = r_modeAck;
  assign bus.current_mode = r_currentMode;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for the VGA mode controller: reset sequence, mode switches,
// custom fields, same-mode requests, ignored requests, held frame_end, reset mid-switch.
module tb_vga_timing_controller;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  vga_timing_controller_if #(.WIDTH(10)) bus ();

  vga_timing_controller #(
    .WIDTH(10),
    .SETTLE_FRAMES(2),
    .DEFAULT_MODE(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // 10-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic checkTiming(input string tag,
                             input int unsigned hs, input int unsigned hb,
                             input int unsigned ha, input int unsigned hf,
                             input int unsigned vs, input int unsigned vb,
                             input int unsigned va, input int unsigned vf);
    checkOutput({tag, ".h_sp"}, bus.h_sp, hs);
    checkOutput({tag, ".h_bp"}, bus.h_bp, hb);
    checkOutput({tag, ".h_av"}, bus.h_av, ha);
    checkOutput({tag, ".h_fp"}, bus.h_fp, hf);
    checkOutput({tag, ".v_sp"}, bus.v_sp, vs);
    checkOutput({tag, ".v_bp"}, bus.v_bp, vb);
    checkOutput({tag, ".v_av"}, bus.v_av, va);
    checkOutput({tag, ".v_fp"}, bus.v_fp, vf);
  endtask

  task automatic checkStatus(input string tag, input int unsigned tr, input int unsigned ve,
                             input int unsigned bz, input int unsigned ack);
    checkOutput({tag, ".timing_reset"}, bus.timing_reset, tr);
    checkOutput({tag, ".video_enable"}, bus.video_enable, ve);
    checkOutput({tag, ".busy"}, bus.busy, bz);
    checkOutput({tag, ".mode_ack"}, bus.mode_ack, ack);
  endtask

  // Advance one cycle; outputs are then sampled 1 unit after the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One-cycle frame_end pulse; returns just after the edge that sees it
  task automatic pulseFrame();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
  endtask

  // One-cycle mode request
  task automatic applyStimulus(input logic [1:0] sel);
    bus.mode_req = 1'b1;
    bus.mode_sel = sel;
    tick();
    bus.mode_req = 1'b0;
  endtask

  task automatic cfgWrite(input logic [2:0] addr, input logic [9:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset        = 1'b0;
    bus.mode_req  = 1'b0;
    bus.mode_sel  = 2'd0;
    bus.frame_end = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 3'd0;
    bus.cfg_data  = 10'd0;

    // 1: reset held, then settle over two frame edges
    tick(3);
    checkTiming("rst", 96, 48, 640, 16, 2, 33, 480, 10);
    checkStatus("rst", 1, 0, 1, 0);
    checkOutput("rst.mode", bus.current_mode, 0);
    reset = 1'b1;
    tick();
    checkStatus("rel", 0, 0, 1, 0);
    pulseFrame();
    checkStatus("rel.fe1", 0, 0, 1, 0);
    tick();
    pulseFrame();
    checkStatus("rel.fe2", 0, 1, 0, 1);
    tick();
    checkStatus("rel.run", 0, 1, 0, 0);

    // 2: switch to sim-small mode
    applyStimulus(2'd2);
    checkStatus("m2.pend", 0, 1, 1, 0);
    checkOutput("m2.pend.h_sp", bus.h_sp, 96);
    tick(2);
    checkOutput("m2.pend.v_av", bus.v_av, 480);
    pulseFrame();
    checkTiming("m2.swap", 2, 3, 5, 2, 2, 3, 5, 2);
    checkStatus("m2.swap", 1, 0, 1, 0);
    checkOutput("m2.swap.mode", bus.current_mode, 2);
    tick();
    checkStatus("m2.settle", 0, 0, 1, 0);
    pulseFrame();
    checkStatus("m2.fe1", 0, 0, 1, 0);
    tick();
    pulseFrame();
    checkStatus("m2.fe2", 0, 1, 0, 1);
    tick();

    // 3: custom fields, with a zero stored as one
    for (int i = 0; i < 8; i++) begin
      cfgWrite(3'(i), 10'(10 + i));
    end
    cfgWrite(3'd4, 10'd0);
    checkTiming("cfg.live", 2, 3, 5, 2, 2, 3, 5, 2);
    applyStimulus(2'd3);
    pulseFrame();
    checkTiming("m3.swap", 10, 11, 12, 13, 1, 15, 16, 17);
    checkOutput("m3.swap.mode", bus.current_mode, 3);
    tick();
    pulseFrame();
    tick();
    pulseFrame();
    checkStatus("m3.done", 0, 1, 0, 1);
    tick();

    // 4: request the mode already live
    applyStimulus(2'd3);
    checkStatus("same", 0, 1, 0, 1);
    tick();
    checkStatus("same.after", 0, 1, 0, 0);
    checkOutput("same.mode", bus.current_mode, 3);

    // 5: request during PEND ignored; held frame_end counts once
    applyStimulus(2'd2);
    applyStimulus(2'd1);
    checkOutput("pend.busy", bus.busy, 1);
    checkOutput("pend.mode", bus.current_mode, 3);
    pulseFrame();
    checkOutput("ign.mode", bus.current_mode, 2);
    checkOutput("ign.h_sp", bus.h_sp, 2);
    tick();
    bus.frame_end = 1'b1;
    tick(5);
    bus.frame_end = 1'b0;
    tick();
    checkStatus("held", 0, 0, 1, 0);
    pulseFrame();
    checkStatus("held.fe2", 0, 1, 0, 1);
    checkOutput("held.mode", bus.current_mode, 2);
    tick();

    // 6: reset during PEND aborts the switch
    applyStimulus(2'd1);
    checkOutput("abort.pend", bus.busy, 1);
    reset = 1'b0;
    tick();
    checkTiming("abort.rst", 96, 48, 640, 16, 2, 33, 480, 10);
    checkStatus("abort.rst", 1, 0, 1, 0);
    checkOutput("abort.mode", bus.current_mode, 0);
    reset = 1'b1;
    tick();
    checkStatus("abort.rel", 0, 0, 1, 0);
    pulseFrame();
    checkStatus("abort.fe1", 0, 0, 1, 0);
    tick();
    pulseFrame();
    checkStatus("abort.fe2", 0, 1, 0, 1);
    checkOutput("abort.h_sp", bus.h_sp, 96);
    tick();

    // 800x600 table, then custom registers back at sim-small values after reset
    applyStimulus(2'd1);
    pulseFrame();
    checkTiming("m1", 128, 88, 800, 40, 4, 23, 600, 1);
    tick();
    pulseFrame();
    tick();
    pulseFrame();
    tick();
    applyStimulus(2'd3);
    pulseFrame();
    checkTiming("m3.rst", 2, 3, 5, 2, 2, 3, 5, 2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
